kalman_result_buffer: RTL and testbench

- Downstream consumer of the Kalman core result port (Mem2_we / Mem2_addrw / Mem2_data, WIP_flag).
- Captures each filter iteration's result writes into a ping-pong buffer and saturates 36-bit results to 32 bits.
- Commits the frame atomically when WIP falls, so the DSP reads a coherent snapshot over EMIF while the next iteration is written.
- Sits between the Kalman instance and the EMIF read mux, in the clk_DSP domain.

---
 rtl/kalman_result_buffer.sv | 142 ++++++++++++++
 tb/tb_kalman_result_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kalman_result_buffer.sv
// Ping-pong result buffer behind the Kalman core: saturates 36-bit results to 32 bits and
// exposes a frame to EMIF reads only when WIP falls, so the DSP always sees a coherent snapshot.
module kalman_result_buffer #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 64,
  parameter int IN_W   = 36,
  parameter int OUT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [IN_W-1:0]   mem_data_i,
  input  logic              wip_i,
  input  logic              lock_i,
  input  logic              clr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [OUT_W-1:0]  rd_data_o,
  output logic              rd_bank_o,
  output logic [15:0]       frame_cnt_o,
  output logic              new_frame_o,
  output logic              sat_o,
  output logic              overrun_o,
  output logic              addr_err_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, COMMIT} state_t;

  state_t           r_state;
  logic [1:0]       r_rst_sync;
  logic             r_wip_q;
  logic             r_wrote_any;
  logic             r_rd_bank;
  logic             r_new_frame;
  logic             r_sat;
  logic             r_overrun;
  logic             r_addr_err;
  logic [15:0]      r_frame_cnt;
  logic [OUT_W-1:0] r_rd_data;
  logic [OUT_W-1:0] r_mem [2][DEPTH];

  logic                w_rst_n;
  logic                w_wr_ok;
  logic                w_wr_bad;
  logic                w_rd_ok;
  logic                w_in_range;
  logic                w_sat_hit;
  logic [IN_W-OUT_W:0] w_head;
  logic [OUT_W-1:0]    w_wr_data;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;

  // Asynchronous assertion, release re-timed to clk_i so no flop sees a late deassertion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_wr_ok  = mem_we_i & (mem_addr_i <  ADDR_W'(DEPTH));
  assign w_wr_bad = mem_we_i & (mem_addr_i >= ADDR_W'(DEPTH));
  assign w_rd_ok  = rd_addr_i < ADDR_W'(DEPTH);
  assign w_wr_idx = mem_addr_i[IDX_W-1:0];
  assign w_rd_idx = rd_addr_i[IDX_W-1:0];

  // The value fits OUT_W signed bits only when every bit above the OUT_W sign bit copies it.
  assign w_head     = mem_data_i[IN_W-1:OUT_W-1];
  assign w_in_range = (&w_head) | ~(|w_head);
  assign w_wr_data  = w_in_range ? mem_data_i[OUT_W-1:0]
                                 : (mem_data_i[IN_W-1] ? MAX_NEG : MAX_POS);
  assign w_sat_hit  = w_wr_ok & ~w_in_range;

  // NOTE: RAM has no reset; its content is undefined after reset, and a reset port would
  // stop it mapping onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) r_mem[~r_rd_bank][w_wr_idx] <= w_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order; later statements win on conflict.
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_wip_q     <= 1'b0;
      r_wrote_any <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
      r_new_frame <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_wip_q     <= wip_i;
      r_new_frame <= 1'b0;
      if (clr_i) begin
        r_sat      <= 1'b0;
        r_overrun  <= 1'b0;
        r_addr_err <= 1'b0;
      end
      case (r_state)
        IDLE:   if (wip_i && !r_wip_q) r_state <= BUSY;
        BUSY:   if (!wip_i && r_wip_q) r_state <= COMMIT;
        COMMIT: begin
          r_state     <= wip_i ? BUSY : IDLE;
          r_wrote_any <= 1'b0;
          if (r_wrote_any) begin
            if (lock_i) begin
              r_overrun <= 1'b1;
            end else begin
              r_rd_bank   <= ~r_rd_bank;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_new_frame <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // A write in the COMMIT cycle belongs to the next frame, so it overrides the clear.
      if (w_wr_ok)   r_wrote_any <= 1'b1;
      if (w_sat_hit) r_sat       <= 1'b1;
      if (w_wr_bad)  r_addr_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n)     r_rd_data <= '0;
    else if (rd_en_i) r_rd_data <= w_rd_ok ? r_mem[r_rd_bank][w_rd_idx] : '0;
  end

  assign rd_data_o   = r_rd_data;
  assign rd_bank_o   = r_rd_bank;
  assign frame_cnt_o = r_frame_cnt;
  assign new_frame_o = r_new_frame;
  assign sat_o       = r_sat;
  assign overrun_o   = r_overrun;
  assign addr_err_o  = r_addr_err;

endmodule

// File: tb/tb_kalman_result_buffer.sv
// Self-checking bench for kalman_result_buffer: frame-level reference model with randomized
// result writes, reads, locks and flag clears.
module tb_kalman_result_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [8:0]  mem_addr = '0;
  logic [35:0] mem_data = '0;
  logic        wip = 1'b0;
  logic        lock = 1'b0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_bank;
  logic [15:0] frame_cnt;
  logic        new_frame;
  logic        sat;
  logic        overrun;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  // Reference model: two banks of words, the visible bank, counter, sticky flags.
  logic [31:0] m_bank [2][64];
  bit          m_vld  [2][64];
  bit          m_rd;
  logic [15:0] m_cnt;
  bit          m_sat, m_ovr, m_aerr, m_wrote;

  logic [8:0]  q_addr [$];
  logic [35:0] q_data [$];

  kalman_result_buffer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .wip_i(wip), .lock_i(lock), .clr_i(clr),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_bank_o(rd_bank), .frame_cnt_o(frame_cnt), .new_frame_o(new_frame),
    .sat_o(sat), .overrun_o(overrun), .addr_err_o(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sat_val(input logic [35:0] d, output bit hit);
    longint v;
    v   = $signed(d);
    hit = 1'b1;
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    hit = 1'b0;
    return d[31:0];
  endfunction

  function automatic void model_reset();
    m_rd = 0; m_cnt = '0; m_sat = 0; m_ovr = 0; m_aerr = 0; m_wrote = 0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 64; i++) m_vld[b][i] = 0;
  endfunction

  function automatic void model_write_bank(input bit b, input logic [8:0] a, input logic [35:0] d);
    bit hit;
    if (a >= 9'd64) begin
      m_aerr = 1;
      return;
    end
    m_bank[b][int'(a)] = sat_val(d, hit);
    m_vld[b][int'(a)]  = 1;
    if (hit) m_sat = 1;
    m_wrote = 1;
  endfunction

  function automatic bit model_commit(input bit lk);
    bit pulse = 0;
    if (m_wrote) begin
      if (lk) m_ovr = 1;
      else begin
        m_rd  = !m_rd;
        m_cnt = m_cnt + 16'd1;
        pulse = 1;
      end
    end
    m_wrote = 0;
    return pulse;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [8:0] a, output bit known);
    known = 1;
    if (a >= 9'd64) return 32'h0;
    known = m_vld[m_rd][int'(a)];
    return m_bank[m_rd][int'(a)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [35:0] d);
    mem_we = 1; mem_addr = a; mem_data = d;
    tick();
    mem_we = 0;
    model_write_bank(!m_rd, a, d);
  endtask

  task automatic do_read(input logic [8:0] a, output logic [31:0] got);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
    got = rd_data;
  endtask

  task automatic do_clear();
    clr = 1;
    tick();
    clr = 0;
    m_sat = 0; m_ovr = 0; m_aerr = 0;
  endtask

  task automatic read_cmp(input string tag, input logic [8:0] a);
    logic [31:0] got, exp;
    bit known;
    exp = exp_rd(a, known);
    do_read(a, got);
    if (known) begin
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s rd[%0d] got=%h exp=%h", tag, a, got, exp); end
    end
  endtask

  // One frame: WIP rise, queued writes, WIP fall, the COMMIT cycle, then the commit result.
  task automatic run_frame(input string tag, input bit lk);
    bit pulse;
    wip = 1; lock = lk;
    tick();
    foreach (q_addr[i]) do_write(q_addr[i], q_data[i]);
    wip = 0;
    tick();
    tick();
    pulse = model_commit(lk);
    checks++; if (new_frame !== pulse) begin errors++; $display("FAIL %s new_frame got=%b exp=%b", tag, new_frame, pulse); end
    checks++; if (rd_bank !== m_rd)    begin errors++; $display("FAIL %s rd_bank got=%b exp=%b", tag, rd_bank, m_rd); end
    checks++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL %s frame_cnt got=%h exp=%h", tag, frame_cnt, m_cnt); end
    checks++; if (overrun !== m_ovr)   begin errors++; $display("FAIL %s overrun got=%b exp=%b", tag, overrun, m_ovr); end
    tick();
    checks++; if (new_frame !== 1'b0)  begin errors++; $display("FAIL %s pulse_width got=%b exp=0", tag, new_frame); end
    lock = 0;
    q_addr.delete(); q_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({rd_data, rd_bank, frame_cnt, new_frame, sat, overrun, addr_err} !== 54'h0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {rd_data, rd_bank, frame_cnt, new_frame, sat, overrun, addr_err});
    end
    @(negedge clk) rst_n = 1;
    tick(); tick(); tick();
    model_reset();
  endtask

  task automatic test_basic();
    logic [31:0] held;
    q_addr.push_back(9'd0); q_data.push_back(36'h0_0000_1234);
    q_addr.push_back(9'd1); q_data.push_back(36'hF_FFFF_FFFE);
    run_frame("basic", 0);
    read_cmp("basic", 9'd0);
    read_cmp("basic", 9'd1);
    held = rd_data;
    rd_addr = 9'd0;
    tick();
    checks++; if (rd_data !== held) begin errors++; $display("FAIL basic_hold got=%h exp=%h", rd_data, held); end
  endtask

  task automatic test_saturation();
    q_addr.push_back(9'd2); q_data.push_back(36'h7_FFFF_FFFF);
    q_addr.push_back(9'd3); q_data.push_back(36'h8_0000_0000);
    run_frame("sat", 0);
    checks++; if (sat !== m_sat) begin errors++; $display("FAIL sat_set got=%b exp=%b", sat, m_sat); end
    read_cmp("sat", 9'd2);
    read_cmp("sat", 9'd3);
    do_clear();
    checks++; if (sat !== m_sat) begin errors++; $display("FAIL sat_clr got=%b exp=%b", sat, m_sat); end
    // Clear and a saturating write on the same edge: the set must win.
    clr = 1;
    m_sat = 0; m_ovr = 0; m_aerr = 0;
    do_write(9'd4, 36'h7_0000_0000);
    clr = 0;
    checks++; if (sat !== m_sat) begin errors++; $display("FAIL sat_set_wins got=%b exp=%b", sat, m_sat); end
    do_clear();
  endtask

  task automatic test_overrun();
    q_addr.push_back(9'd0); q_data.push_back(36'h11);
    run_frame("ovr_a", 0);
    q_addr.push_back(9'd0); q_data.push_back(36'h22);
    run_frame("ovr_b", 1);
    read_cmp("ovr_b", 9'd0);
    q_addr.push_back(9'd0); q_data.push_back(36'h33);
    run_frame("ovr_c", 0);
    read_cmp("ovr_c", 9'd0);
    do_clear();
    checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL ovr_clr got=%b exp=%b", overrun, m_ovr); end
  endtask

  task automatic test_addr_err();
    q_addr.push_back(9'd0);   q_data.push_back(36'h0ABC);
    q_addr.push_back(9'd64);  q_data.push_back(36'h0DEF);
    q_addr.push_back(9'd511); q_data.push_back(36'h0555);
    run_frame("aerr", 0);
    checks++; if (addr_err !== m_aerr) begin errors++; $display("FAIL aerr_set got=%b exp=%b", addr_err, m_aerr); end
    read_cmp("aerr", 9'd0);
    read_cmp("aerr", 9'd64);
    read_cmp("aerr", 9'd511);
    do_clear();
  endtask

  task automatic test_empty();
    run_frame("empty", 0);
    run_frame("empty_locked", 1);
  endtask

  // Read and write in the COMMIT cycle while WIP rises again for the next frame.
  task automatic test_commit_overlap();
    logic [31:0] exp, got;
    bit known, pulse, wb;
    q_addr.push_back(9'd7); q_data.push_back({4'h0, $urandom() & 32'h7FFF_FFFF});
    run_frame("ovl_pre", 0);
    wip = 1;
    tick();
    do_write(9'd7, 36'h0_1357_9BDF);
    wip = 0;
    tick();
    exp = exp_rd(9'd7, known);
    rd_en = 1; rd_addr = 9'd7; wip = 1;
    mem_we = 1; mem_addr = 9'd8; mem_data = 36'h0_0000_5A5A;
    tick();
    rd_en = 0; mem_we = 0;
    wb = !m_rd;
    pulse = model_commit(0);
    model_write_bank(wb, 9'd8, 36'h0_0000_5A5A);
    checks++; if (rd_data !== exp)    begin errors++; $display("FAIL ovl_old_bank got=%h exp=%h", rd_data, exp); end
    checks++; if (new_frame !== pulse) begin errors++; $display("FAIL ovl_pulse got=%b exp=%b", new_frame, pulse); end
    checks++; if (rd_bank !== m_rd)   begin errors++; $display("FAIL ovl_bank got=%b exp=%b", rd_bank, m_rd); end
    read_cmp("ovl_busy", 9'd8);
    read_cmp("ovl_busy", 9'd7);
    run_frame("ovl_next", 0);
    read_cmp("ovl_next", 9'd7);
    got = '0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [35:0] d;
    logic [8:0]  first;
    int n;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        r = $urandom();
        case ($urandom_range(0, 2))
          0:       d = {{4{r[31]}}, r};
          1:       d = {4'($urandom_range(0, 15)), r};
          default: d = ($urandom_range(0, 1) != 0) ? 36'h0_7FFF_FFFF : 36'hF_8000_0000;
        endcase
        q_addr.push_back(9'($urandom_range(0, 70)));
        q_data.push_back(d);
      end
      first = q_addr[0];
      run_frame("rand", $urandom_range(0, 3) == 0);
      read_cmp("rand", first);
      read_cmp("rand", 9'($urandom_range(0, 63)));
      checks++; if ({sat, addr_err} !== {m_sat, m_aerr}) begin
        errors++; $display("FAIL rand_flags got=%b%b exp=%b%b", sat, addr_err, m_sat, m_aerr);
      end
      if ($urandom_range(0, 2) == 0) do_clear();
    end
    do_clear();
  endtask

  // Back-to-back two-cycle frames until the counter rolls over.
  task automatic test_wrap();
    int n;
    bit pulse;
    n = 65536 - int'(m_cnt) + 2;
    mem_we = 1; mem_addr = 9'd9; mem_data = 36'h1;
    wip = 1;
    tick();
    for (int k = 0; k < n; k++) begin
      wip = 0;
      tick();
      wip = (k != n - 1);
      if (k == n - 1) mem_we = 0;
      tick();
      m_wrote = 1;
      pulse = model_commit(0);
      if (m_cnt == 16'hFFFF || m_cnt == 16'h0000 || m_cnt == 16'h0001) begin
        checks++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL wrap_cnt got=%h exp=%h", frame_cnt, m_cnt); end
      end
    end
    checks++; if (rd_bank !== m_rd) begin errors++; $display("FAIL wrap_bank got=%b exp=%b", rd_bank, m_rd); end
    m_wrote = 0;
    m_vld[0][9] = 0; m_vld[1][9] = 0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    q_addr.push_back(9'd3); q_data.push_back(36'h0_0000_1357);
    run_frame("arst_pre", 0);
    do_read(9'd3, got);
    wip = 1;
    tick();
    do_write(9'd3, 36'h7_0000_0000);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rd_data, rd_bank, frame_cnt, new_frame, sat, overrun, addr_err} !== 54'h0) begin
      errors++; $display("FAIL arst_outputs got=%h exp=0", {rd_data, rd_bank, frame_cnt, new_frame, sat, overrun, addr_err});
    end
    wip = 0;
    @(negedge clk) rst_n = 1;
    tick(); tick(); tick();
    model_reset();
    q_addr.push_back(9'd0); q_data.push_back(36'h0_0000_CAFE);
    run_frame("arst_post", 0);
    read_cmp("arst_post", 9'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_addr_err();
    test_empty();
    test_commit_overlap();
    test_random();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
